// File: rtl/trivium_out_fifo_if.sv
// Handshake bundle between the Trivium core, the output FIFO and the downstream consumer.
// The FIFO takes the slave view; the core/consumer side takes the master view.
interface trivium_out_fifo_if #(
  parameter int AW = 9
) ();
  logic [7:0]  in_data;
  logic        in_wr;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  fifo_cnd;
  logic [AW:0] level;
  logic        blk_done;
  logic        ovf;

  modport slave (
    input  in_data,
    input  in_wr,
    input  out_ready,
    output out_data,
    output out_valid,
    output fifo_cnd,
    output level,
    output blk_done,
    output ovf
  );

  modport master (
    output in_data,
    output in_wr,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  fifo_cnd,
    input  level,
    input  blk_done,
    input  ovf
  );
endinterface

// File: rtl/trivium_out_fifo.sv
// Byte FIFO behind the Trivium core: absorbs ciphertext bursts, serves a valid/ready consumer
// and reports occupancy (fifo_cnd) so the core only starts a burst when a whole block fits.
module trivium_out_fifo #(
  parameter int DEPTH = 512,
  parameter int BLOCK = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  trivium_out_fifo_if.slave bus
);

  localparam logic [AW:0]   FULL_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   BLK_C     = (AW+1)'(BLOCK);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [7:0]    BCNT_LAST = 8'(BLOCK - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  function automatic logic [1:0] cnd_decode(input logic ovf_v, input logic [AW:0] cnt_v);
    logic [1:0] res;
    if (ovf_v) begin
      res = 2'b11;
    end else if (cnt_v == FULL_C) begin
      res = 2'b10;
    end else if ((FULL_C - cnt_v) < BLK_C) begin
      res = 2'b01;
    end else begin
      res = 2'b00;
    end
    return res;
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    cnd_q, cnd_d;
  state_t        state_q;
  logic [7:0]    bcnt_q;
  logic          blk_done_q;

  logic          full_s;
  logic          wr_acc_s;
  logic          rd_acc_s;

  assign full_s   = (count_q == FULL_C);
  assign wr_acc_s = bus.in_wr & ~full_s & ~clr;
  assign rd_acc_s = valid_q & bus.out_ready & ~clr;

  // Next-state for pointers, occupancy, flags and the pre-fetched head byte.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    data_d   = 8'h00;
    if (clr) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
      ovf_d    = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (bus.in_wr & full_s);
    end
    valid_d = (count_d != CNT_ZERO);
    // The new head may be the byte landing this very edge (write at empty, or read of the last byte).
    if (!valid_d) begin
      data_d = 8'h00;
    end else if (wr_acc_s && (rd_ptr_d == wr_ptr_q)) begin
      data_d = bus.in_data;
    end else begin
      data_d = mem[rd_ptr_d];
    end
    cnd_d = cnd_decode(ovf_d, count_d);
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  // Pointer, occupancy and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      cnd_q    <= 2'b00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      cnd_q    <= cnd_d;
    end
  end

  // Burst tracker: counts accepted writes and pulses blk_done on the last byte of a block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bcnt_q     <= 8'd0;
      blk_done_q <= 1'b0;
    end else if (clr) begin
      state_q    <= IDLE;
      bcnt_q     <= 8'd0;
      blk_done_q <= 1'b0;
    end else if (wr_acc_s) begin
      case (state_q)
        IDLE: begin
          state_q    <= FILL;
          bcnt_q     <= 8'd1;
          blk_done_q <= 1'b0;
        end
        FILL: begin
          if (bcnt_q == BCNT_LAST) begin
            state_q    <= IDLE;
            bcnt_q     <= 8'd0;
            blk_done_q <= 1'b1;
          end else begin
            state_q    <= FILL;
            bcnt_q     <= bcnt_q + 8'd1;
            blk_done_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          bcnt_q     <= 8'd0;
          blk_done_q <= 1'b0;
        end
      endcase
    end else begin
      blk_done_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.fifo_cnd  = cnd_q;
  assign bus.level     = count_q;
  assign bus.blk_done  = blk_done_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/trivium_out_fifo.md
# trivium_out_fifo

Byte FIFO that sits directly downstream of the Trivium keystream/encryption core. It absorbs 256-byte ciphertext bursts strobed out by the core and presents them to the consumer over a valid/ready handshake. It reports occupancy back to the core on the 2-bit `fifo_cnd` status bus, which the core polls before starting the next burst.

## Interface
- `DEPTH`, 512: storage in bytes; power of two, ≥ 2·`BLOCK`.
- `BLOCK`, 256: burst length produced by the core, in bytes.
- `AW`, $clog2(`DEPTH`): pointer width.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clr` in 1: synchronous flush. Empties the FIFO and clears the sticky flags.
- `in_data` in 8: ciphertext byte from the core (`stream`).
- `in_wr` in 1: write strobe from the core (`wt_sgn`), one byte per cycle.
- `out_data` out 8: head byte; reads 8'h00 whenever `out_valid`=0.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `fifo_cnd` out 2: occupancy status to the core (encoding below).
- `level` out AW+1: bytes stored, 0..`DEPTH`.
- `blk_done` out 1: one-cycle pulse when the `BLOCK`-th byte of a burst is stored.
- `ovf` out 1: sticky overflow flag; a byte was dropped.

## Operation
- Storage: register array `mem[DEPTH]` with `wr_ptr`, `rd_ptr` (AW bits, wrap modulo `DEPTH`) and `count` (AW+1 bits). `level` = `count`.
- Write: if `in_wr` and `count` < `DEPTH`, then `mem[wr_ptr]` ← `in_data` and `wr_ptr`+1.
- Read: if `out_valid` and `out_ready`, then `rd_ptr`+1.
- `out_valid` = (`count` ≠ 0). `out_data` = `mem[rd_ptr]` when valid.
- Count update: `count` ← `count` + accepted write − accepted read.
- Simultaneous read and write at 0 < `count` < `DEPTH`: both happen and `count` is unchanged.
- Full (`count`=`DEPTH`): a write is dropped even if a read occurs in the same cycle. `ovf` ← 1 and the dropped byte is not counted.
- Empty: a read cannot occur because `out_valid`=0. A write at empty is visible the next cycle.
- `fifo_cnd`, decoded from the current registered state:
  - 2'b11 if `ovf`=1
  - else 2'b10 if `count`=`DEPTH`
  - else 2'b01 if `DEPTH`−`count` < `BLOCK`
  - else 2'b00, meaning there is room for a whole burst, so the core may proceed.
- Burst tracker FSM, states IDLE and FILL, with `bcnt` (8 bits, counting accepted writes):
  - IDLE: an accepted write moves to FILL with `bcnt`=1.
  - FILL: each accepted write increments `bcnt`. When the write that makes `bcnt`=`BLOCK` is accepted, `blk_done` pulses for that cycle, `bcnt` ← 0 and the FSM returns to IDLE.
  - Dropped writes do not advance `bcnt`.
- `clr` (synchronous, highest priority after `rst`): pointers, `count`, `bcnt` ← 0; FSM ← IDLE; `ovf` ← 0. Any write or read in the same cycle is ignored.

## Timing
- Reset values: `out_valid`=0, `out_data`=8'h00, `level`=0, `fifo_cnd`=2'b00, `blk_done`=0, `ovf`=0, FSM=IDLE. `mem` is not reset.
- Write-to-`out_valid` latency: byte written at edge k, `out_valid`=1 during cycle k+1.
- Read handshake: `out_data` is stable while `out_valid`=1 and `out_ready`=0. After an accepted read at edge k, the next byte is presented in cycle k+1.
- Throughput: one write and one read per cycle sustained.
- `fifo_cnd`, `level` and `ovf` reflect the state after the most recent edge; there is no extra pipeline stage.
- `blk_done` is registered and high for exactly one cycle after the edge that stores the last byte of a burst.
- `rst` asserted mid-burst returns all state to reset values immediately. After release, the first accepted write starts a new burst with `bcnt`=1.
- Pointer wrap: `wr_ptr` and `rd_ptr` wrap from `DEPTH`−1 to 0 with no gap or duplicate.

## Test plan
- Reset/idle: assert `rst` for 3 cycles, then release → `out_valid`=0, `out_data`=8'h00, `level`=0, `fifo_cnd`=2'b00, `ovf`=0.
- Single burst: 256 consecutive `in_wr` with data 0..255 and `out_ready`=0 → `level`=256, `blk_done` one pulse after byte 255, `fifo_cnd`=2'b00. Then hold `out_ready`=1 → bytes 0..255 out in order and `level` returns to 0.
- Threshold: write 257 bytes with no reads → `fifo_cnd`=2'b01 once `level`=257. Reading 1 byte → 2'b00.
- Full/overflow: write 513 bytes with no reads → `level`=512 and `fifo_cnd`=2'b10 after byte 511. The 513th byte is dropped, `ovf`=1 and `fifo_cnd`=2'b11. Pulse `clr` → `level`=0, `fifo_cnd`=2'b00, `ovf`=0.
- Wrap with concurrency: for 2000 cycles drive random `in_wr` (50%) and `out_ready` (60%) with an incrementing data byte → output sequence equals input sequence exactly, `ovf` stays 0, and `level` always equals writes minus reads.
- Reset mid-burst: write 100 bytes, pulse `rst`, then write 256 bytes → exactly one `blk_done`, on the 256th post-reset byte, and `level`=256.
